// File: rtl/blockade_pkg.sv
// blockade_pkg
// Shared definitions for the Blockade player-input conditioning stage:
//   - joystick bit indices of the raw MiSTer joystick words
//   - bit positions inside the debounced vector and the in0/in1/in2 port bytes
//   - coin FSM state type
//   - opposite-direction cleaning helper (used when BLOCKADE_INPUTS_SOCD_EN is defined)
package blockade_pkg;

  // Raw joystick word bit indices (identical for both players).
  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;
  localparam int JOY_COIN  = 4;
  localparam int JOY_START = 5;

  // Layout of the debounced vector: P1 dirs, P2 dirs, coin, start.
  localparam int DB_P1_LSB = 0;
  localparam int DB_P2_LSB = 4;
  localparam int DB_COIN   = 8;
  localparam int DB_START  = 9;
  localparam int DB_W      = 10;

  // in0 bit positions.
  localparam int IN0_START_N = 0;
  localparam int IN0_COIN_N  = 7;

  // in1/in2 bit positions (directions, active low).
  localparam int INDIR_UP    = 0;
  localparam int INDIR_RIGHT = 1;
  localparam int INDIR_DOWN  = 2;
  localparam int INDIR_LEFT  = 3;

  typedef enum logic [1:0] {
    COIN_IDLE,
    COIN_PULSE,
    COIN_HOLD
  } coin_state_t;

  // Opposing directions cancel: left+right gives neither, up+down gives neither.
  function automatic logic [3:0] socd_clean(input logic [3:0] dirs);
    logic [3:0] res;
    res = dirs;
    if (dirs[JOY_RIGHT] && dirs[JOY_LEFT]) begin
      res[JOY_RIGHT] = 1'b0;
      res[JOY_LEFT]  = 1'b0;
    end
    if (dirs[JOY_UP] && dirs[JOY_DOWN]) begin
      res[JOY_UP]   = 1'b0;
      res[JOY_DOWN] = 1'b0;
    end
    return res;
  endfunction

  // Map active-high joystick directions onto an active-low in1/in2 byte.
  function automatic logic [7:0] dir_byte(input logic [3:0] dirs);
    logic [7:0] b;
    b              = 8'hFF;
    b[INDIR_UP]    = ~dirs[JOY_UP];
    b[INDIR_RIGHT] = ~dirs[JOY_RIGHT];
    b[INDIR_DOWN]  = ~dirs[JOY_DOWN];
    b[INDIR_LEFT]  = ~dirs[JOY_LEFT];
    return b;
  endfunction

endpackage

// File: rtl/input_debounce.sv
// input_debounce
// Two-flop synchroniser followed by an independent counter-based debouncer
// per bit. A debounced bit follows its synchronised input only after the two
// have differed for CYCLES consecutive clocks; any agreeing cycle restarts
// the count.
// Parameters:
//   WIDTH  - number of bits conditioned
//   CYCLES - consecutive differing cycles before a debounced bit changes (1..255)
// Ports:
//   clk     in  1      system clock
//   reset_n in  1      asynchronous active-low reset
//   i_raw   in  WIDTH  raw asynchronous inputs
//   o_deb   out WIDTH  debounced, registered outputs
module input_debounce #(
  parameter int WIDTH  = 10,
  parameter int CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_deb
);

  localparam int              CW       = $clog2(CYCLES + 1);
  // The update happens on the cycle the count would reach CYCLES.
  localparam logic [CW-1:0]   CNT_LAST = CW'(CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_deb;
  logic [CW-1:0]    r_cnt [WIDTH];

  // Stage 1/2: synchroniser
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Stage 3: per-bit stability counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_deb <= '0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign o_deb = r_deb;

endmodule

// File: rtl/blockade_inputs.sv
// blockade_inputs
// Player-input conditioning for the Blockade core. Synchronises and debounces
// the used joystick bits, turns a coin press into a fixed number of
// frame-latched coin_n=0 samples, and updates the active-low port bytes only
// on the rising edge of vblank so the CPU never sees a mid-frame change.
// Optional feature macro: BLOCKADE_INPUTS_SOCD_EN (opposite-direction cleaning).
// Parameters:
//   DEBOUNCE_CYCLES   (1..255) stable cycles before a debounced bit changes
//   COIN_PULSE_FRAMES (1..15)  frame latches that carry coin asserted
// Ports:
//   clk         in  1   system clock (clk_sys)
//   reset_n     in  1   asynchronous active-low reset
//   vblank      in  1   vertical blank, synchronous to clk
//   joy_p1      in  16  player 1 joystick (0 R,1 L,2 D,3 U,4 coin,5 start)
//   joy_p2      in  16  player 2 joystick
//   in0         out 8   bit7 coin_n, bit0 start_n, others 1
//   in1         out 8   P1 dirs active low (0 U,1 R,2 D,3 L), bits 7:4 = 1
//   in2         out 8   P2 dirs, same layout
//   coin_active out 1   high while coin FSM is in PULSE
module blockade_inputs
  import blockade_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int COIN_PULSE_FRAMES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vblank,
  input  logic [15:0] joy_p1,
  input  logic [15:0] joy_p2,
  output logic [7:0]  in0,
  output logic [7:0]  in1,
  output logic [7:0]  in2,
  output logic        coin_active
);

  localparam logic [3:0] FCNT_LAST = 4'(COIN_PULSE_FRAMES - 1);

  logic [DB_W-1:0] w_raw;
  logic [DB_W-1:0] w_deb;
  logic [3:0]      w_p1_dirs;
  logic [3:0]      w_p2_dirs;
  logic            w_vb_rise;
  logic            w_coin_rise;
  coin_state_t     w_state_nxt;
  logic [3:0]      w_fcnt_nxt;
  logic [7:0]      w_in0_nxt;

  logic            r_vblank_q;
  logic            r_coin_q;
  coin_state_t     r_state;
  logic [3:0]      r_fcnt;
  logic [7:0]      r_in0;
  logic [7:0]      r_in1;
  logic [7:0]      r_in2;
  logic            r_coin_active;

  assign w_raw[DB_P1_LSB +: 4] = joy_p1[3:0];
  assign w_raw[DB_P2_LSB +: 4] = joy_p2[3:0];
  assign w_raw[DB_COIN]        = joy_p1[JOY_COIN]  | joy_p2[JOY_COIN];
  assign w_raw[DB_START]       = joy_p1[JOY_START] | joy_p2[JOY_START];

  // Stage 1-3: synchronise and debounce
  input_debounce #(
    .WIDTH  (DB_W),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .reset_n (reset_n),
    .i_raw   (w_raw),
    .o_deb   (w_deb)
  );

`ifdef BLOCKADE_INPUTS_SOCD_EN
  assign w_p1_dirs = socd_clean(w_deb[DB_P1_LSB +: 4]);
  assign w_p2_dirs = socd_clean(w_deb[DB_P2_LSB +: 4]);
`else
  assign w_p1_dirs = w_deb[DB_P1_LSB +: 4];
  assign w_p2_dirs = w_deb[DB_P2_LSB +: 4];
`endif

  assign w_vb_rise   = vblank & ~r_vblank_q;
  assign w_coin_rise = w_deb[DB_COIN] & ~r_coin_q;

  // Stage 4: edge detectors
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vblank_q <= 1'b0;
      r_coin_q   <= 1'b0;
    end else begin
      r_vblank_q <= vblank;
      r_coin_q   <= w_deb[DB_COIN];
    end
  end

  // Coin FSM. Latches see the current (registered) state, so the final
  // vb_rise in PULSE still outputs coin_n=0 and a coin edge coinciding with
  // vb_rise is not yet visible in that latch.
  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    case (r_state)
      COIN_IDLE: begin
        if (w_coin_rise) begin
          w_state_nxt = COIN_PULSE;
          w_fcnt_nxt  = 4'd0;
        end
      end
      COIN_PULSE: begin
        if (w_vb_rise) begin
          w_fcnt_nxt = r_fcnt + 4'd1;
          if (r_fcnt == FCNT_LAST) w_state_nxt = COIN_HOLD;
        end
      end
      COIN_HOLD: begin
        // Wait for release so a held coin yields a single pulse.
        if (!w_deb[DB_COIN]) w_state_nxt = COIN_IDLE;
      end
      default: begin
        w_state_nxt = COIN_IDLE;
        w_fcnt_nxt  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= COIN_IDLE;
      r_fcnt        <= 4'd0;
      r_coin_active <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_fcnt        <= w_fcnt_nxt;
      r_coin_active <= (w_state_nxt == COIN_PULSE);
    end
  end

  always_comb begin
    w_in0_nxt              = 8'hFF;
    w_in0_nxt[IN0_COIN_N]  = ~(r_state == COIN_PULSE);
    w_in0_nxt[IN0_START_N] = ~w_deb[DB_START];
  end

  // Stage 5: frame latch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in0 <= 8'hFF;
      r_in1 <= 8'hFF;
      r_in2 <= 8'hFF;
    end else if (w_vb_rise) begin
      r_in0 <= w_in0_nxt;
      r_in1 <= dir_byte(w_p1_dirs);
      r_in2 <= dir_byte(w_p2_dirs);
    end
  end

  assign in0         = r_in0;
  assign in1         = r_in1;
  assign in2         = r_in2;
  assign coin_active = r_coin_active;

endmodule

// File: tb/tb_blockade_inputs.sv
// tb_blockade_inputs
// Directed self-checking bench for blockade_inputs with default parameters
// (DEBOUNCE_CYCLES=16, COIN_PULSE_FRAMES=4). Expected values are hand-derived.
module tb_blockade_inputs;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        vblank  = 1'b0;
  logic [15:0] joy_p1  = 16'h0;
  logic [15:0] joy_p2  = 16'h0;
  logic [7:0]  in0;
  logic [7:0]  in1;
  logic [7:0]  in2;
  logic        coin_active;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  blockade_inputs #(
    .DEBOUNCE_CYCLES   (16),
    .COIN_PULSE_FRAMES (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .vblank      (vblank),
    .joy_p1      (joy_p1),
    .joy_p2      (joy_p2),
    .in0         (in0),
    .in1         (in1),
    .in2         (in2),
    .coin_active (coin_active)
  );

  // Advance n clocks, leaving time 1 unit after the last rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One 8-cycle frame; outputs are captured one cycle after the vblank rise.
  task automatic do_frame(output logic [7:0] o0, output logic [7:0] o1,
                          output logic [7:0] o2, output logic ca);
    vblank = 1'b1;
    tick(1);
    o0 = in0;
    o1 = in1;
    o2 = in2;
    ca = coin_active;
    tick(1);
    vblank = 1'b0;
    tick(6);
  endtask

  task automatic test_reset();
    logic [7:0] o0, o1, o2;
    logic       ca;
    reset_n = 1'b0;
    tick(3);
    n_tests++;
    if ({in0, in1, in2, coin_active} !== {24'hFFFFFF, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_hold: got %h %h %h ca=%b expected ff ff ff ca=0", in0, in1, in2, coin_active);
    end
    reset_n = 1'b1;
    tick(2);
    for (int f = 0; f < 10; f++) begin
      do_frame(o0, o1, o2, ca);
      n_tests++;
      if ({o0, o1, o2, ca} !== {24'hFFFFFF, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_idle_frame%0d: got %h %h %h ca=%b expected ff ff ff ca=0", f, o0, o1, o2, ca);
      end
    end
  endtask

  task automatic test_debounce();
    logic [7:0] o0, o1, o2;
    logic       ca;
    joy_p1 = 16'h0008;  // P1 up
    tick(20);
    n_tests++;
    if (in1 !== 8'hFF) begin
      n_fail++;
      $display("FAIL up_before_vb: got %h expected ff", in1);
    end
    do_frame(o0, o1, o2, ca);
    n_tests++;
    if (o1 !== 8'hFE) begin
      n_fail++;
      $display("FAIL up_latched: got %h expected fe", o1);
    end
    joy_p1 = 16'h0;
    tick(20);
    do_frame(o0, o1, o2, ca);
    n_tests++;
    if (o1 !== 8'hFF) begin
      n_fail++;
      $display("FAIL up_released: got %h expected ff", o1);
    end
    joy_p1 = 16'h0008;  // 10-cycle glitch
    tick(10);
    joy_p1 = 16'h0;
    tick(20);
    do_frame(o0, o1, o2, ca);
    n_tests++;
    if (o1 !== 8'hFF) begin
      n_fail++;
      $display("FAIL glitch10: got %h expected ff", o1);
    end
    joy_p2 = 16'h0008;  // P2 up
    tick(20);
    do_frame(o0, o1, o2, ca);
    n_tests++;
    if (o2 !== 8'hFE || o1 !== 8'hFF) begin
      n_fail++;
      $display("FAIL p2_up: got in1=%h in2=%h expected in1=ff in2=fe", o1, o2);
    end
    joy_p2 = 16'h0020;  // P2 start, P2 up released
    tick(20);
    do_frame(o0, o1, o2, ca);
    n_tests++;
    if (o0 !== 8'hFE || o2 !== 8'hFF) begin
      n_fail++;
      $display("FAIL start: got in0=%h in2=%h expected in0=fe in2=ff", o0, o2);
    end
    joy_p2 = 16'h0;
    tick(20);
    do_frame(o0, o1, o2, ca);
    n_tests++;
    if (o0 !== 8'hFF) begin
      n_fail++;
      $display("FAIL start_release: got %h expected ff", o0);
    end
  endtask

  // Debounce update on the same edge as the latch: latch keeps the old value.
  task automatic test_deb_vb_same();
    logic [7:0] o0, o1, o2;
    logic       ca;
    joy_p1 = 16'h0004;  // P1 down; debounced value changes on the 18th edge
    tick(17);
    do_frame(o0, o1, o2, ca);
    n_tests++;
    if (o1 !== 8'hFF) begin
      n_fail++;
      $display("FAIL deb_vb_same: got %h expected ff", o1);
    end
    do_frame(o0, o1, o2, ca);
    n_tests++;
    if (o1 !== 8'hFB) begin
      n_fail++;
      $display("FAIL deb_vb_next: got %h expected fb", o1);
    end
    joy_p1 = 16'h0;
    tick(20);
    do_frame(o0, o1, o2, ca);
  endtask

  task automatic test_coin_pulse();
    logic [7:0] o0, o1, o2;
    logic       ca;
    logic [7:0] exp_n;
    logic [7:0] exp_ca;
    int         zeros;
    exp_n  = 8'b1111_0000;  // bit f = expected coin_n of frame f
    exp_ca = 8'b0000_0111;
    zeros  = 0;
    joy_p2 = 16'h0010;
    tick(18);
    n_tests++;
    if (coin_active !== 1'b0) begin
      n_fail++;
      $display("FAIL coin_active_early: got %b expected 0", coin_active);
    end
    tick(1);
    n_tests++;
    if (coin_active !== 1'b1) begin
      n_fail++;
      $display("FAIL coin_active_rise: got %b expected 1", coin_active);
    end
    n_tests++;
    if (in0 !== 8'hFF) begin
      n_fail++;
      $display("FAIL coin_no_latch_yet: got %h expected ff", in0);
    end
    tick(81);
    joy_p2 = 16'h0;
    for (int f = 0; f < 8; f++) begin
      do_frame(o0, o1, o2, ca);
      if (o0[7] == 1'b0) zeros++;
      n_tests++;
      if (o0[7] !== exp_n[f] || ca !== exp_ca[f]) begin
        n_fail++;
        $display("FAIL coin_frame%0d: got coin_n=%b ca=%b expected coin_n=%b ca=%b",
                 f, o0[7], ca, exp_n[f], exp_ca[f]);
      end
    end
    n_tests++;
    if (zeros != 4) begin
      n_fail++;
      $display("FAIL coin_count: got %0d expected 4", zeros);
    end
  endtask

  task automatic test_coin_held();
    logic [7:0] o0, o1, o2;
    logic       ca;
    int         zeros;
    zeros  = 0;
    joy_p1 = 16'h0010;
    tick(25);
    for (int f = 0; f < 10; f++) begin
      do_frame(o0, o1, o2, ca);
      if (o0[7] == 1'b0) zeros++;
    end
    n_tests++;
    if (zeros != 4) begin
      n_fail++;
      $display("FAIL coin_held_count: got %0d expected 4", zeros);
    end
    joy_p1 = 16'h0;
    tick(25);
    for (int f = 0; f < 2; f++) begin
      do_frame(o0, o1, o2, ca);
      n_tests++;
      if (o0[7] !== 1'b1 || ca !== 1'b0) begin
        n_fail++;
        $display("FAIL coin_after_release%0d: got coin_n=%b ca=%b expected coin_n=1 ca=0", f, o0[7], ca);
      end
    end
    zeros  = 0;
    joy_p1 = 16'h0010;
    tick(25);
    for (int f = 0; f < 6; f++) begin
      do_frame(o0, o1, o2, ca);
      if (o0[7] == 1'b0) zeros++;
    end
    n_tests++;
    if (zeros != 4) begin
      n_fail++;
      $display("FAIL coin_repress_count: got %0d expected 4", zeros);
    end
    joy_p1 = 16'h0;
    tick(25);
  endtask

  // Coin edge on the vb_rise cycle: FSM enters PULSE, that latch shows coin_n=1.
  task automatic test_coin_vb_same();
    logic [7:0] o0, o1, o2;
    logic       ca;
    logic [7:0] exp_n;
    exp_n  = 8'b0010_0001;  // frame 0: 1, frames 1-4: 0, frame 5: 1
    joy_p2 = 16'h0010;
    tick(18);
    for (int f = 0; f < 6; f++) begin
      do_frame(o0, o1, o2, ca);
      if (f == 0) joy_p2 = 16'h0;
      n_tests++;
      if (o0[7] !== exp_n[f]) begin
        n_fail++;
        $display("FAIL coin_vb_same_frame%0d: got coin_n=%b expected %b", f, o0[7], exp_n[f]);
      end
    end
    tick(25);
  endtask

  task automatic test_reset_mid_pulse();
    logic [7:0] o0, o1, o2;
    logic       ca;
    joy_p1 = 16'h0010;
    tick(25);
    joy_p1 = 16'h0;
    do_frame(o0, o1, o2, ca);
    n_tests++;
    if (o0[7] !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_pulse_frame1: got coin_n=%b expected 0", o0[7]);
    end
    vblank = 1'b1;
    tick(1);
    n_tests++;
    if (in0[7] !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_pulse_frame2: got coin_n=%b expected 0", in0[7]);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (in0 !== 8'hFF || coin_active !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: got in0=%h ca=%b expected in0=ff ca=0", in0, coin_active);
    end
    vblank = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    for (int f = 0; f < 6; f++) begin
      do_frame(o0, o1, o2, ca);
      n_tests++;
      if (o0 !== 8'hFF || ca !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_no_pulse%0d: got in0=%h ca=%b expected in0=ff ca=0", f, o0, ca);
      end
    end
  endtask

  task automatic test_socd();
    logic [7:0] o0, o1, o2;
    logic       ca;
    logic [7:0] exp1;
    logic [7:0] exp2;
`ifdef BLOCKADE_INPUTS_SOCD_EN
    exp1 = 8'hFF;
    exp2 = 8'hFF;
`else
    exp1 = 8'hF5;
    exp2 = 8'hFA;
`endif
    joy_p1 = 16'h0003;  // left + right
    joy_p2 = 16'h000C;  // up + down
    tick(20);
    do_frame(o0, o1, o2, ca);
    n_tests++;
    if (o1 !== exp1) begin
      n_fail++;
      $display("FAIL socd_lr: got %h expected %h", o1, exp1);
    end
    n_tests++;
    if (o2 !== exp2) begin
      n_fail++;
      $display("FAIL socd_ud: got %h expected %h", o2, exp2);
    end
    joy_p1 = 16'h0009;  // up + right: not opposing
    joy_p2 = 16'h0;
    tick(20);
    do_frame(o0, o1, o2, ca);
    n_tests++;
    if (o1 !== 8'hFC || o2 !== 8'hFF) begin
      n_fail++;
      $display("FAIL diag: got in1=%h in2=%h expected in1=fc in2=ff", o1, o2);
    end
    joy_p1 = 16'h0;
    tick(20);
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_deb_vb_same();
    test_coin_pulse();
    test_coin_held();
    test_coin_vb_same();
    test_reset_mid_pulse();
    test_socd();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
